// File: rtl/dma_chunk_sched_pkg.sv
// Shared types and helpers for the DMA chunk scheduler.
package dma_sched_pkg;

    localparam int unsigned ADDR_W_DEF   = 64;
    localparam int unsigned SIZE_W_DEF   = 43;
    localparam int unsigned CHUNK_CL_DEF = 256;
    localparam int unsigned CL_BYTE_BITS = 6;

    typedef logic [SIZE_W_DEF-1:0] t_cl_count;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        FINISH
    } t_sched_state;

    function automatic t_cl_count chunk_min(input t_cl_count rem, input t_cl_count max_cl);
        return (rem > max_cl) ? max_cl : rem;
    endfunction

endpackage

// File: rtl/dma_chunk_sched_if.sv
// Request/completion bundle between the chunk scheduler and the DMA read/write engine.
interface dma_chunk_sched_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned SIZE_W = 43
);
    logic              dma_rd_go;
    logic [ADDR_W-1:0] dma_rd_addr;
    logic [SIZE_W-1:0] dma_rd_size;
    logic              dma_wr_go;
    logic [ADDR_W-1:0] dma_wr_addr;
    logic [SIZE_W-1:0] dma_wr_size;
    logic              dma_rd_done;
    logic              dma_wr_done;

    modport master (
        output dma_rd_go, dma_rd_addr, dma_rd_size,
        output dma_wr_go, dma_wr_addr, dma_wr_size,
        input  dma_rd_done, dma_wr_done
    );

    modport slave (
        input  dma_rd_go, dma_rd_addr, dma_rd_size,
        input  dma_wr_go, dma_wr_addr, dma_wr_size,
        output dma_rd_done, dma_wr_done
    );
endinterface

// File: rtl/dma_chunk_sched.sv
// Splits one host-to-host copy job into chunks of at most CHUNK_CL cachelines and
// drives paired read/write requests into the DMA engine, one chunk at a time.
module dma_chunk_sched
    import dma_sched_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned SIZE_W   = SIZE_W_DEF,
    parameter int unsigned CHUNK_CL = CHUNK_CL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [SIZE_W-1:0] size,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [SIZE_W-1:0] chunks_done,
    dma_chunk_sched_if.master dma
);

    t_sched_state      state_q, state_d;
    logic [ADDR_W-1:0] cur_src_q, cur_src_d;
    logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
    logic [SIZE_W-1:0] rem_q, rem_d;
    logic [SIZE_W-1:0] chunks_q, chunks_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              abort_pend_q, abort_pend_d;
    logic              dma_go_q, dma_go_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [SIZE_W-1:0] dsize_q, dsize_d;
    logic              eng_idle;
    logic [ADDR_W-1:0] chunk_bytes;

    assign eng_idle    = dma.dma_rd_done && dma.dma_wr_done;
    assign chunk_bytes = ADDR_W'(dsize_q) << CL_BYTE_BITS;

    always_comb begin
        state_d      = state_q;
        cur_src_d    = cur_src_q;
        cur_dst_d    = cur_dst_q;
        rem_d        = rem_q;
        chunks_d     = chunks_q;
        busy_d       = busy_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        dma_go_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        dsize_d      = dsize_q;

        if (state_q != IDLE && abort) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    cur_src_d = src_addr;
                    cur_dst_d = dst_addr;
                    rem_d     = size;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    chunks_d  = '0;
                    if (size == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        busy_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (eng_idle) begin
                    dma_go_d  = 1'b1;
                    rd_addr_d = cur_src_q;
                    wr_addr_d = cur_dst_q;
                    dsize_d   = SIZE_W'(chunk_min(t_cl_count'(rem_q), t_cl_count'(CHUNK_CL)));
                    state_d   = SETTLE;
                end
            end
            // Engine done flags are stale for one cycle after go.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (eng_idle) begin
                    chunks_d  = chunks_q + SIZE_W'(1);
                    rem_d     = rem_q - dsize_q;
                    cur_src_d = cur_src_q + chunk_bytes;
                    cur_dst_d = cur_dst_q + chunk_bytes;
                    state_d   = (rem_d == '0 || abort_pend_d) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                busy_d       = 1'b0;
                done_d       = 1'b1;
                aborted_d    = abort_pend_q;
                abort_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            rem_q        <= '0;
            chunks_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            dma_go_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            dsize_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_src_q    <= cur_src_d;
            cur_dst_q    <= cur_dst_d;
            rem_q        <= rem_d;
            chunks_q     <= chunks_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            dma_go_q     <= dma_go_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            dsize_q      <= dsize_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign chunks_done     = chunks_q;
    assign dma.dma_rd_go   = dma_go_q;
    assign dma.dma_wr_go   = dma_go_q;
    assign dma.dma_rd_addr = rd_addr_q;
    assign dma.dma_wr_addr = wr_addr_q;
    assign dma.dma_rd_size = dsize_q;
    assign dma.dma_wr_size = dsize_q;

endmodule

// File: tb/tb_dma_chunk_sched.sv
// Directed bench for dma_chunk_sched with a simple behavioural DMA engine.
module tb_dma_chunk_sched;

    localparam int ADDR_W = 64;
    localparam int SIZE_W = 43;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              go = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [SIZE_W-1:0] size = '0;
    logic              busy, done, aborted;
    logic [SIZE_W-1:0] chunks_done;

    dma_chunk_sched_if #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) dma_if ();

    dma_chunk_sched #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .CHUNK_CL(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .abort       (abort),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .size        (size),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .chunks_done (chunks_done),
        .dma         (dma_if)
    );

    always #5 clk = ~clk;

    // Engine model: done drops the cycle after go, rises size/32 + latency cycles later.
    int   eng_lat  = 4;
    int   wr_extra = 0;
    int   rd_cnt   = 0;
    int   wr_cnt   = 0;
    logic eng_rd_done = 1'b1;
    logic eng_wr_done = 1'b1;

    always @(posedge clk) begin
        if (dma_if.dma_rd_go) begin
            eng_rd_done <= 1'b0;
            rd_cnt      <= int'(dma_if.dma_rd_size[15:5]) + eng_lat;
        end else if (rd_cnt > 0) begin
            rd_cnt <= rd_cnt - 1;
            if (rd_cnt == 1) eng_rd_done <= 1'b1;
        end
        if (dma_if.dma_wr_go) begin
            eng_wr_done <= 1'b0;
            wr_cnt      <= int'(dma_if.dma_wr_size[15:5]) + eng_lat + wr_extra;
        end else if (wr_cnt > 0) begin
            wr_cnt <= wr_cnt - 1;
            if (wr_cnt == 1) eng_wr_done <= 1'b1;
        end
    end

    assign dma_if.dma_rd_done = eng_rd_done;
    assign dma_if.dma_wr_done = eng_wr_done;

    logic [ADDR_W-1:0] q_rd_addr[$];
    logic [ADDR_W-1:0] q_wr_addr[$];
    logic [SIZE_W-1:0] q_size[$];
    int                pair_err  = 0;
    int                early_err = 0;
    bit                busy_seen = 1'b0;

    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (dma_if.dma_rd_go || dma_if.dma_wr_go) begin
            if (!(dma_if.dma_rd_go && dma_if.dma_wr_go) || dma_if.dma_rd_size != dma_if.dma_wr_size)
                pair_err++;
            if (!(eng_rd_done && eng_wr_done)) early_err++;
            q_rd_addr.push_back(dma_if.dma_rd_addr);
            q_wr_addr.push_back(dma_if.dma_wr_addr);
            q_size.push_back(dma_if.dma_rd_size);
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_mon();
        q_rd_addr.delete();
        q_wr_addr.delete();
        q_size.delete();
        busy_seen = 1'b0;
    endtask

    task automatic start_job(input logic [SIZE_W-1:0] sz, input logic [ADDR_W-1:0] s,
                             input logic [ADDR_W-1:0] d);
        @(posedge clk); #1;
        go = 1'b1; size = sz; src_addr = s; dst_addr = d;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int abort_after, input string name);
        int  ctr   = -1;
        bit  armed = 1'b0;
        bit  ok    = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            abort = 1'b0;
            if (ctr == 0) abort = 1'b1;
            if (ctr >= 0) ctr--;
            if (dma_if.dma_rd_go && !armed && abort_after >= 0) begin
                armed = 1'b1;
                ctr   = abort_after;
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        abort = 1'b0;
        if (!ok) check({name, "_timeout"}, 128'(done), 128'(1));
    endtask

    typedef struct {
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        int                abort_after;
        int                exp_pulses;
        logic [SIZE_W-1:0] exp_chunks;
        logic              exp_aborted;
        logic [SIZE_W-1:0] exp_last_size;
        logic [ADDR_W-1:0] exp_last_rd;
        logic [ADDR_W-1:0] exp_last_wr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{43'd600,  64'h1000,   64'h80000,  -1, 3, 43'd3, 1'b0, 43'd88,  64'h9000,   64'h88000};
        vecs[1] = '{43'd512,  64'h20000,  64'h40000,  -1, 2, 43'd2, 1'b0, 43'd256, 64'h24000,  64'h44000};
        vecs[2] = '{43'd1024, 64'h100000, 64'h200000,  0, 1, 43'd1, 1'b1, 43'd256, 64'h100000, 64'h200000};
        vecs[3] = '{43'd1,    64'h3000,   64'h7000,   -1, 1, 43'd1, 1'b0, 43'd1,   64'h3000,   64'h7000};
        vecs[4] = '{43'd256,  64'h40,     64'h80,     -1, 1, 43'd1, 1'b0, 43'd256, 64'h40,     64'h80};
        vecs[5] = '{43'd257,  64'h0,      64'h10000,  -1, 2, 43'd2, 1'b0, 43'd1,   64'h4000,   64'h14000};
        vecs[6] = '{43'd0,    64'h5000,   64'h6000,   -1, 0, 43'd0, 1'b0, 43'd0,   64'h0,      64'h0};
        vecs[7] = '{43'd512,  64'hFFFF_FFFF_FFFF_C000, 64'hFFFF_FFFF_FFFF_C000, -1, 2, 43'd2, 1'b0,
                    43'd256, 64'h0, 64'h0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_status", {busy, done, aborted, chunks_done}, '0);
        check("reset_dma", {dma_if.dma_rd_go, dma_if.dma_wr_go, dma_if.dma_rd_addr,
                            dma_if.dma_wr_addr}, '0);
        check("reset_sizes", {dma_if.dma_rd_size, dma_if.dma_wr_size}, '0);
        rst_n = 1'b1;

        // Multi-chunk job: full per-chunk trace.
        clear_mon();
        start_job(43'd600, 64'h1000, 64'h80000);
        wait_done(-1, "trace600");
        check("trace_pulses", q_size.size(), 3);
        if (q_size.size() == 3) begin
            check("trace_size0", q_size[0], 43'd256);
            check("trace_size1", q_size[1], 43'd256);
            check("trace_size2", q_size[2], 43'd88);
            check("trace_rd0", q_rd_addr[0], 64'h1000);
            check("trace_rd1", q_rd_addr[1], 64'h5000);
            check("trace_rd2", q_rd_addr[2], 64'h9000);
            check("trace_wr0", q_wr_addr[0], 64'h80000);
            check("trace_wr1", q_wr_addr[1], 64'h84000);
            check("trace_wr2", q_wr_addr[2], 64'h88000);
        end

        for (int i = 0; i < 8; i++) begin
            clear_mon();
            start_job(vecs[i].size, vecs[i].src, vecs[i].dst);
            wait_done(vecs[i].abort_after, $sformatf("v%0d", i));
            check($sformatf("v%0d_done", i), done, 1'b1);
            check($sformatf("v%0d_busy", i), busy, 1'b0);
            check($sformatf("v%0d_aborted", i), aborted, vecs[i].exp_aborted);
            check($sformatf("v%0d_chunks", i), chunks_done, vecs[i].exp_chunks);
            check($sformatf("v%0d_pulses", i), q_size.size(), vecs[i].exp_pulses);
            if (vecs[i].exp_pulses > 0 && q_size.size() > 0) begin
                check($sformatf("v%0d_first_rd", i), q_rd_addr[0], vecs[i].src);
                check($sformatf("v%0d_last_size", i), q_size[q_size.size()-1], vecs[i].exp_last_size);
                check($sformatf("v%0d_last_rd", i), q_rd_addr[q_rd_addr.size()-1], vecs[i].exp_last_rd);
                check($sformatf("v%0d_last_wr", i), q_wr_addr[q_wr_addr.size()-1], vecs[i].exp_last_wr);
            end
        end

        // size==0: done exactly two cycles after go, busy never raised.
        clear_mon();
        @(posedge clk); #1;
        go = 1'b1; size = '0;
        @(posedge clk); #1;
        go = 1'b0;
        @(negedge clk);
        check("zero_done_cleared", done, 1'b0);
        @(negedge clk);
        check("zero_done_at_go2", done, 1'b1);
        check("zero_chunks", chunks_done, '0);
        check("zero_pulses", q_size.size(), 0);
        check("zero_busy_seen", busy_seen, 1'b0);

        // Slow write completion plus an ignored go mid-job.
        clear_mon();
        wr_extra = 50;
        start_job(43'd512, 64'h6000, 64'hA000);
        repeat (10) @(negedge clk);
        go = 1'b1; size = 43'd9; src_addr = 64'hDEAD_0000; dst_addr = 64'hBEEF_0000;
        @(negedge clk);
        go = 1'b0;
        wait_done(-1, "slow_wr");
        check("slow_pulses", q_size.size(), 2);
        check("slow_chunks", chunks_done, 43'd2);
        if (q_size.size() == 2) begin
            check("slow_rd1", q_rd_addr[1], 64'hA000);
            check("slow_wr1", q_wr_addr[1], 64'hE000);
            check("slow_size1", q_size[1], 43'd256);
        end
        wr_extra = 0;

        // Asynchronous reset in WAIT of the second chunk.
        clear_mon();
        eng_lat = 20;
        start_job(43'd1024, 64'h1000, 64'h2000);
        for (int c = 0; c < 2000 && q_size.size() < 2; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_chunks", chunks_done, 43'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_status", {busy, done, aborted, chunks_done}, '0);
        check("rst_dma", {dma_if.dma_rd_go, dma_if.dma_wr_go, dma_if.dma_rd_addr,
                          dma_if.dma_wr_addr}, '0);
        check("rst_sizes", {dma_if.dma_rd_size, dma_if.dma_wr_size}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        start_job(43'd1, 64'h3000, 64'h4000);
        wait_done(-1, "post_rst");
        check("post_rst_chunks", chunks_done, 43'd1);
        check("post_rst_pulses", q_size.size(), 1);
        if (q_size.size() == 1) begin
            check("post_rst_size", q_size[0], 43'd1);
            check("post_rst_rd", q_rd_addr[0], 64'h3000);
        end

        check("pair_errors", pair_err, 0);
        check("early_go_errors", early_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
